// File: rtl/imm_inst_encoder_if.sv
// Request/response bundle for imm_inst_encoder: immediate-pack request channel
// in, encoded-instruction channel out, each with its own valid/ready pair.
interface imm_inst_encoder_if;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_immSrc;
    logic [31:0] i_inst;
    logic [31:0] i_imm;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_inst;
    logic        o_err;

    modport master (
        output i_valid, i_immSrc, i_inst, i_imm, i_ready,
        input  o_ready, o_valid, o_inst, o_err
    );

    modport slave (
        input  i_valid, i_immSrc, i_inst, i_imm, i_ready,
        output o_ready, o_valid, o_inst, o_err
    );
endinterface

// File: rtl/imm_inst_encoder.sv
// Scatters an immediate into an RV32I template with a range check, behind one
// registered valid/ready stage. Define IMM_ENC_LI_EN to split LUI into LUI+ADDI.
module imm_inst_encoder #(
    parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    imm_inst_encoder_if.slave    bus
);

    typedef enum logic [1:0] {EMPTY, FULL, PEND} stateT;

    stateT       state;
    logic [31:0] instQ;
    logic        errQ;
    logic [31:0] pendInst;

    logic [31:0] word1;
    logic [31:0] word2;
    logic        err1;
    logic        isPair;
    logic        accept;

    logic [31:0] t;
    logic [31:0] imm;
    assign t   = bus.i_inst;
    assign imm = bus.i_imm;

`ifdef IMM_ENC_LI_EN
    // Upper part rounded so that the sign-extended ADDI lands on imm.
    logic [19:0] luiHi;
    assign luiHi = imm[31:12] + {19'd0, imm[11]};
`endif

    always_comb begin
        word1  = t;
        err1   = 1'b0;
        isPair = 1'b0;
        word2  = {imm[11:0], t[11:7], 3'b000, t[11:7], 7'h13};
        case (bus.i_immSrc)
            3'b010: begin
                word1[24:20] = imm[4:0];
                err1         = |imm[31:5];
            end
            3'b011: begin
                word1[31:25] = imm[11:5];
                word1[11:7]  = imm[4:0];
                err1         = ~((&imm[31:11]) | ~(|imm[31:11]));
            end
            3'b100: begin
                word1[31:12] = imm[31:12];
                err1         = |imm[11:0];
`ifdef IMM_ENC_LI_EN
                if (t[6:0] == 7'b0110111 && (|imm[11:0])) begin
                    isPair       = 1'b1;
                    word1[31:12] = luiHi;
                    err1         = 1'b0;
                end
`endif
            end
            3'b101: begin
                word1[31]    = imm[12];
                word1[7]     = imm[11];
                word1[30:25] = imm[10:5];
                word1[11:8]  = imm[4:1];
                err1         = ~((&imm[31:12]) | ~(|imm[31:12])) | imm[0];
            end
            3'b111: begin
                word1[31]    = imm[20];
                word1[30:21] = imm[10:1];
                word1[20]    = imm[11];
                word1[19:12] = imm[19:12];
                err1         = ~((&imm[31:20]) | ~(|imm[31:20])) | imm[0];
            end
            default: begin
                word1[31:20] = imm[11:0];
                err1         = ~((&imm[31:11]) | ~(|imm[31:11]));
            end
        endcase
    end

    assign bus.o_ready = (state == EMPTY) || (state == FULL && bus.i_ready);
    assign bus.o_valid = (state != EMPTY);
    assign bus.o_inst  = instQ;
    assign bus.o_err   = errQ;
    assign accept      = bus.i_valid && bus.o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the held second word is reset as well, so a reset mid-pair cannot leak it later.
            state    <= EMPTY;
            instQ    <= RESET_INST;
            errQ     <= 1'b0;
            pendInst <= RESET_INST;
        end else begin
            case (state)
                EMPTY, FULL: begin
                    if (accept) begin
                        instQ    <= word1;
                        errQ     <= err1;
                        pendInst <= word2;
                        state    <= isPair ? PEND : FULL;
                    end else if (state == FULL && bus.i_ready) begin
                        instQ <= RESET_INST;
                        errQ  <= 1'b0;
                        state <= EMPTY;
                    end
                end
                PEND: begin
                    if (bus.i_ready) begin
                        instQ <= pendInst;
                        errQ  <= 1'b0;
                        state <= FULL;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Self-checking bench for imm_inst_encoder: vector table through a scoreboard,
// plus hand sequences for latency, backpressure, LUI pairing and reset.
module tb_imm_inst_encoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    imm_inst_encoder_if bus();

    imm_inst_encoder #(.RESET_INST(32'h0000_0013)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } expT;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] t;
        logic [31:0] imm;
        logic [31:0] expInst;
        logic        expErr;
    } vecT;

    expT sb[$];
    int  checks   = 0;
    int  failures = 0;
    int  taken    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on every downstream take and checks
    // that a stalled word does not change.
    initial begin
        logic        held;
        logic [31:0] heldInst;
        logic        heldErr;
        expT         e;
        held = 1'b0;
        heldInst = '0;
        heldErr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
                continue;
            end
            if (held && bus.o_valid) begin
                check("stable_inst", bus.o_inst, heldInst);
                check("stable_err", {31'd0, bus.o_err}, {31'd0, heldErr});
            end
            held     = bus.o_valid && !bus.i_ready;
            heldInst = bus.o_inst;
            heldErr  = bus.o_err;
            if (bus.o_valid && bus.i_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %h expected none", bus.o_inst);
                end else begin
                    e = sb.pop_front();
                    check("word_inst", bus.o_inst, e.inst);
                    check("word_err", {31'd0, bus.o_err}, {31'd0, e.err});
                    taken++;
                end
            end
        end
    end

    task automatic send(input logic [2:0] src, input logic [31:0] t, input logic [31:0] imm,
                        input expT e1, input bit pair, input expT e2, output int waits);
        bit acc;
        acc   = 1'b0;
        waits = 0;
        bus.i_valid  = 1'b1;
        bus.i_immSrc = src;
        bus.i_inst   = t;
        bus.i_imm    = imm;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = bus.o_ready;
            if (acc) begin
                sb.push_back(e1);
                if (pair) sb.push_back(e2);
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        vecT vecs[14];
        expT none;
        expT e1;
        expT e2;
        int  waits;
        int  waitSum;
        int  takenStart;
        bit  pair;

        vecs[0]  = '{3'b001, 32'h0000_0093, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
        vecs[1]  = '{3'b001, 32'h0000_0093, 32'h0000_0800, 32'h8000_0093, 1'b1};
        vecs[2]  = '{3'b000, 32'h0000_0013, 32'h0000_07FF, 32'h7FF0_0013, 1'b0};
        vecs[3]  = '{3'b110, 32'h000F_F013, 32'hFFFF_F800, 32'h800F_F013, 1'b0};
        vecs[4]  = '{3'b101, 32'h0000_0063, 32'h0000_0800, 32'h0000_00E3, 1'b0};
        vecs[5]  = '{3'b101, 32'h0000_0063, 32'h0000_0001, 32'h0000_0063, 1'b1};
        vecs[6]  = '{3'b101, 32'h0000_0063, 32'hFFFF_F000, 32'h8000_0063, 1'b0};
        vecs[7]  = '{3'b111, 32'h0000_006F, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0};
        vecs[8]  = '{3'b111, 32'h0000_006F, 32'h0010_0000, 32'h8000_006F, 1'b1};
        vecs[9]  = '{3'b010, 32'h0000_1013, 32'h0000_001F, 32'h01F0_1013, 1'b0};
        vecs[10] = '{3'b010, 32'h0000_1013, 32'h0000_0020, 32'h0000_1013, 1'b1};
        vecs[11] = '{3'b010, 32'h4000_5013, 32'h0000_0003, 32'h4030_5013, 1'b0};
        vecs[12] = '{3'b011, 32'h0000_2023, 32'hFFFF_FFFC, 32'hFE00_2E23, 1'b0};
        vecs[13] = '{3'b100, 32'h0000_0117, 32'h1234_5678, 32'h1234_5117, 1'b1};
        none = '{32'h0, 1'b0};

        bus.i_valid  = 1'b0;
        bus.i_ready  = 1'b1;
        bus.i_immSrc = 3'b000;
        bus.i_inst   = 32'h0;
        bus.i_imm    = 32'h0;

        // Reset state.
        rst_n = 1'b0;
        #2;
        check("reset_valid", {31'd0, bus.o_valid}, 32'd0);
        check("reset_inst", bus.o_inst, 32'h0000_0013);
        check("reset_err", {31'd0, bus.o_err}, 32'd0);
        check("reset_ready", {31'd0, bus.o_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // One-cycle latency and return to the reset word.
        @(posedge clk);
        #1;
        bus.i_valid  = 1'b1;
        bus.i_immSrc = 3'b001;
        bus.i_inst   = 32'h0000_0093;
        bus.i_imm    = 32'hFFFF_FFFF;
        @(negedge clk);
        check("ready_empty", {31'd0, bus.o_ready}, 32'd1);
        check("valid_before", {31'd0, bus.o_valid}, 32'd0);
        sb.push_back('{32'hFFF0_0093, 1'b0});
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        check("latency_valid", {31'd0, bus.o_valid}, 32'd1);
        check("latency_inst", bus.o_inst, 32'hFFF0_0093);
        @(posedge clk);
        #1;
        check("drain_valid", {31'd0, bus.o_valid}, 32'd0);
        check("drain_inst", bus.o_inst, 32'h0000_0013);

        // Vector table, back to back with i_ready held high.
        waitSum = 0;
        for (int i = 0; i < 14; i++) begin
            e1 = '{vecs[i].expInst, vecs[i].expErr};
            send(vecs[i].src, vecs[i].t, vecs[i].imm, e1, 1'b0, none, waits);
            waitSum += waits;
        end
        check("throughput_waits", waitSum, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("table_drained", sb.size(), 32'd0);

        // Backpressure: second request stalls for three cycles, then all flow.
        takenStart = taken;
        bus.i_ready = 1'b0;
        send(3'b001, 32'h0000_0093, 32'h0000_0001, '{32'h0010_0093, 1'b0}, 1'b0, none, waits);
        fork
            send(3'b001, 32'h0000_0093, 32'h0000_0002, '{32'h0020_0093, 1'b0}, 1'b0, none, waits);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_ready_low", {31'd0, bus.o_ready}, 32'd0);
                    check("bp_inst_held", bus.o_inst, 32'h0010_0093);
                end
                @(posedge clk);
                #1 bus.i_ready = 1'b1;
            end
        join
        check("bp_waits", waits, 32'd3);
        waitSum = 0;
        send(3'b001, 32'h0000_0093, 32'h0000_0003, '{32'h0030_0093, 1'b0}, 1'b0, none, waits);
        waitSum += waits;
        send(3'b001, 32'h0000_0093, 32'h0000_0004, '{32'h0040_0093, 1'b0}, 1'b0, none, waits);
        waitSum += waits;
        check("bp_stream_waits", waitSum, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_words_taken", taken - takenStart, 32'd4);
        check("bp_drained", sb.size(), 32'd0);

        // LUI with a nonzero low part.
`ifdef IMM_ENC_LI_EN
        pair = 1'b1;
        e1   = '{32'h1234_60B7, 1'b0};
        e2   = '{32'hFFF0_8093, 1'b0};
`else
        pair = 1'b0;
        e1   = '{32'h1234_50B7, 1'b1};
        e2   = none;
`endif
        send(3'b100, 32'h0000_00B7, 32'h1234_5FFF, e1, pair, e2, waits);
        @(negedge clk);
        check("li_first_inst", bus.o_inst, e1.inst);
        check("li_first_ready", {31'd0, bus.o_ready}, {31'd0, ~pair});
        @(negedge clk);
`ifdef IMM_ENC_LI_EN
        check("li_second_inst", bus.o_inst, 32'hFFF0_8093);
        check("li_second_valid", {31'd0, bus.o_valid}, 32'd1);
`else
        check("li_single_gone", {31'd0, bus.o_valid}, 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("li_drained", sb.size(), 32'd0);

        // Reset while a word (the first of a pair when enabled) is presented.
        bus.i_ready = 1'b0;
        send(3'b100, 32'h0000_00B7, 32'h1234_5FFF, e1, pair, e2, waits);
        @(negedge clk);
        check("pre_reset_valid", {31'd0, bus.o_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_valid", {31'd0, bus.o_valid}, 32'd0);
        check("mid_reset_inst", bus.o_inst, 32'h0000_0013);
        check("mid_reset_err", {31'd0, bus.o_err}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.i_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_second_word", {31'd0, bus.o_valid}, 32'd0);
        end

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
